menu_key_decoder: RTL and testbench



---
 rtl/menu_key_decoder_pkg.sv | 41 ++++
 rtl/menu_key_decoder_if.sv | 26 ++
 rtl/menu_key_decoder_scancode_to_key.sv | 34 +++
 rtl/menu_key_decoder.sv | 92 +++++++++
 tb/tb_menu_key_decoder.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/menu_key_decoder_pkg.sv
// Shared constants for the PS/2 menu key decoder and the menu page logic.
// Contents: command encodings, Set-2 scan-code constants, bus widths and the
// decoder FSM state type.
package menu_key_decoder_pkg;

    localparam int unsigned SC_W   = 8;  // scan-code byte width
    localparam int unsigned KEY_W  = 3;  // menu command width
    localparam int unsigned HELD_W = 8;  // one held bit per command code

    // Menu command encodings, also used by the menu page state machine
    typedef enum logic [KEY_W-1:0] {
        KEY_NONE  = 3'd0,
        KEY_UP    = 3'd1,
        KEY_DOWN  = 3'd2,
        KEY_LEFT  = 3'd3,
        KEY_RIGHT = 3'd4,
        KEY_ENTER = 3'd5,
        KEY_ESC   = 3'd6,
        KEY_SPACE = 3'd7
    } key_cmd_e;

    // PS/2 Set-2 scan codes of interest
    localparam logic [SC_W-1:0] SC_EXT   = 8'hE0;
    localparam logic [SC_W-1:0] SC_BRK   = 8'hF0;
    localparam logic [SC_W-1:0] SC_UP    = 8'h75;
    localparam logic [SC_W-1:0] SC_DOWN  = 8'h72;
    localparam logic [SC_W-1:0] SC_LEFT  = 8'h6B;
    localparam logic [SC_W-1:0] SC_RIGHT = 8'h74;
    localparam logic [SC_W-1:0] SC_ENTER = 8'h5A;
    localparam logic [SC_W-1:0] SC_ESC   = 8'h76;
    localparam logic [SC_W-1:0] SC_SPACE = 8'h29;

    // Prefix tracking: E0 seen, F0 seen, E0 F0 seen
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } dec_state_e;

endpackage

// File: rtl/menu_key_decoder_if.sv
// Byte-in / command-out bus of the menu key decoder.
//   scancode_in/scancode_valid : byte stream from the PS/2 receiver
//   key_code_out               : single-cycle menu command per key press
//   key_held                   : per-command held flags (bit 0 unused, always 0)
//   seq_error                  : single-cycle pulse on prefix timeout/misorder
// master = byte source / command consumer, slave = decoder.
interface menu_key_decoder_if;
    import menu_key_decoder_pkg::*;

    logic [SC_W-1:0]   scancode_in;
    logic              scancode_valid;
    logic [KEY_W-1:0]  key_code_out;
    logic [HELD_W-1:0] key_held;
    logic              seq_error;

    modport master (
        output scancode_in, scancode_valid,
        input  key_code_out, key_held, seq_error
    );

    modport slave (
        input  scancode_in, scancode_valid,
        output key_code_out, key_held, seq_error
    );

endinterface

// File: rtl/menu_key_decoder_scancode_to_key.sv
// Combinational map of (extended flag, scan-code byte) to a menu command.
//   ext   : byte was preceded by E0
//   code  : scan-code byte
//   key_c : menu command, KEY_NONE for anything unmapped
module scancode_to_key
    import menu_key_decoder_pkg::*;
(
    input  logic             ext,
    input  logic [SC_W-1:0]  code,
    output logic [KEY_W-1:0] key_c
);

    always_comb begin
        key_c = KEY_NONE;
        if (ext) begin
            case (code)
                SC_UP:    key_c = KEY_UP;
                SC_DOWN:  key_c = KEY_DOWN;
                SC_LEFT:  key_c = KEY_LEFT;
                SC_RIGHT: key_c = KEY_RIGHT;
                SC_ENTER: key_c = KEY_ENTER;  // keypad enter
                default:  key_c = KEY_NONE;
            endcase
        end else begin
            case (code)
                SC_ENTER: key_c = KEY_ENTER;
                SC_ESC:   key_c = KEY_ESC;
                SC_SPACE: key_c = KEY_SPACE;
                default:  key_c = KEY_NONE;
            endcase
        end
    end

endmodule

// File: rtl/menu_key_decoder.sv
// PS/2 Set-2 byte stream to menu command decoder.
// Tracks E0/F0 prefixes, keeps a held flag per command so typematic repeats
// produce no output, and abandons a prefix sequence after TIMEOUT_CYCLES.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of menu_key_decoder_if (bytes in, commands out)
module menu_key_decoder
    import menu_key_decoder_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 650000,
    parameter int unsigned TIMER_W        = 20
) (
    input logic               clk,
    input logic               rst,
    menu_key_decoder_if.slave bus
);

    dec_state_e        state;
    logic [TIMER_W-1:0] timer;

    logic             ext_c;
    logic             brk_c;
    logic             is_prefix_c;
    logic             timeout_c;
    logic [KEY_W-1:0] key_c;

    assign ext_c       = (state == ST_EXT) || (state == ST_EXT_BRK);
    assign brk_c       = (state == ST_BRK) || (state == ST_EXT_BRK);
    assign is_prefix_c = (bus.scancode_in == SC_EXT) || (bus.scancode_in == SC_BRK);
    assign timeout_c   = (state != ST_IDLE) &&
                         (timer == TIMER_W'(TIMEOUT_CYCLES - 1));

    scancode_to_key u_map (
        .ext   (ext_c),
        .code  (bus.scancode_in),
        .key_c (key_c)
    );

    // Prefix FSM, timeout timer, held flags and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            timer            <= '0;
            bus.key_code_out <= KEY_NONE;
            bus.key_held     <= '0;
            bus.seq_error    <= 1'b0;
        end else begin
            bus.key_code_out <= KEY_NONE;
            bus.seq_error    <= 1'b0;

            if (bus.scancode_valid) begin
                // Any accepted byte restarts the timer; a byte in the timeout
                // cycle wins over the timeout.
                timer <= '0;
                if (is_prefix_c) begin
                    case (state)
                        ST_IDLE: state <= (bus.scancode_in == SC_EXT) ? ST_EXT : ST_BRK;
                        ST_EXT: begin
                            if (bus.scancode_in == SC_BRK) begin
                                state <= ST_EXT_BRK;
                            end else begin
                                bus.seq_error <= 1'b1;  // E0 E0: stay, timer restarted
                            end
                        end
                        default: begin
                            bus.seq_error <= 1'b1;
                            state         <= ST_IDLE;
                        end
                    endcase
                end else begin
                    state <= ST_IDLE;
                    if (key_c != KEY_NONE) begin
                        if (brk_c) begin
                            bus.key_held[key_c] <= 1'b0;
                        end else if (!bus.key_held[key_c]) begin
                            bus.key_held[key_c] <= 1'b1;
                            bus.key_code_out    <= key_c;
                        end
                    end
                end
            end else if (state != ST_IDLE) begin
                if (timeout_c) begin
                    state         <= ST_IDLE;
                    timer         <= '0;
                    bus.seq_error <= 1'b1;
                end else begin
                    timer <= timer + TIMER_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_menu_key_decoder.sv
// Self-checking bench for menu_key_decoder: directed sequences followed by
// randomized byte streams, compared every cycle against a prefix-queue model.
module tb_menu_key_decoder;

    localparam int unsigned TO    = 16;
    localparam int unsigned TO_W  = 5;
    localparam int unsigned N_RND = 3000;

    logic clk;
    logic rst;

    menu_key_decoder_if bus_if ();

    menu_key_decoder #(
        .TIMEOUT_CYCLES (TO),
        .TIMER_W        (TO_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state
    logic [7:0] pq[$];          // pending prefix bytes
    int         idle_cnt;       // valid-less cycles since last byte
    logic [7:0] m_held;
    logic [2:0] exp_code;
    logic       exp_err;
    logic [2:0] tbl_n [0:255];  // plain-byte command table
    logic [2:0] tbl_e [0:255];  // E0-prefixed command table
    logic [7:0] pool  [0:11];

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Expected outputs after the next clock edge, from the byte rules
    task automatic model(input logic v, input logic [7:0] b, input logic r);
        logic       ext;
        logic       brk;
        logic [2:0] k;
        exp_code = 3'd0;
        exp_err  = 1'b0;
        if (r) begin
            pq.delete();
            idle_cnt = 0;
            m_held   = 8'h00;
        end else if (v) begin
            idle_cnt = 0;
            if (b == 8'hE0 || b == 8'hF0) begin
                if (pq.size() == 0) begin
                    pq.push_back(b);
                end else if (pq.size() == 1 && pq[0] == 8'hE0 && b == 8'hF0) begin
                    pq.push_back(b);
                end else if (pq.size() == 1 && pq[0] == 8'hE0 && b == 8'hE0) begin
                    exp_err = 1'b1;
                end else begin
                    exp_err = 1'b1;
                    pq.delete();
                end
            end else begin
                ext = (pq.size() > 0) && (pq[0] == 8'hE0);
                brk = (pq.size() > 0) && (pq[pq.size()-1] == 8'hF0);
                k   = ext ? tbl_e[b] : tbl_n[b];
                if (k != 3'd0) begin
                    if (brk) begin
                        m_held[k] = 1'b0;
                    end else if (!m_held[k]) begin
                        m_held[k] = 1'b1;
                        exp_code  = k;
                    end
                end
                pq.delete();
            end
        end else if (pq.size() > 0) begin
            idle_cnt++;
            if (idle_cnt == int'(TO)) begin
                exp_err  = 1'b1;
                idle_cnt = 0;
                pq.delete();
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model, check outputs mid-cycle
    task automatic step(input logic v, input logic [7:0] b, input logic r);
        bus_if.scancode_valid = v;
        bus_if.scancode_in    = v ? b : 8'($urandom);
        rst                   = r;
        model(v, b, r);
        @(negedge clk);
        check("key_code_out", 8'(bus_if.key_code_out), 8'(exp_code));
        check("key_held",     bus_if.key_held,         m_held);
        check("seq_error",    8'(bus_if.seq_error),    8'(exp_err));
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b1, b, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            tbl_n[i] = 3'd0;
            tbl_e[i] = 3'd0;
        end
        tbl_e[8'h75] = 3'd1;
        tbl_e[8'h72] = 3'd2;
        tbl_e[8'h6B] = 3'd3;
        tbl_e[8'h74] = 3'd4;
        tbl_e[8'h5A] = 3'd5;
        tbl_n[8'h5A] = 3'd5;
        tbl_n[8'h76] = 3'd6;
        tbl_n[8'h29] = 3'd7;
        pool[0] = 8'hE0; pool[1]  = 8'hF0; pool[2]  = 8'h75; pool[3]  = 8'h72;
        pool[4] = 8'h6B; pool[5]  = 8'h74; pool[6]  = 8'h5A; pool[7]  = 8'h76;
        pool[8] = 8'h29; pool[9]  = 8'hAA; pool[10] = 8'hFA; pool[11] = 8'h00;
        idle_cnt = 0;
        m_held   = 8'h00;
        bus_if.scancode_valid = 1'b0;
        bus_if.scancode_in    = 8'h00;
        rst = 1'b1;

        // Reset state
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        idle(2);

        // ENTER press and release
        send(8'h5A); idle(1); send(8'hF0); send(8'h5A); idle(3);

        // Typematic UP then release
        for (int i = 0; i < 3; i++) begin send(8'hE0); send(8'h75); idle(1); end
        send(8'hE0); send(8'hF0); send(8'h75); idle(2);

        // Back-to-back DOWN, LEFT and their releases
        send(8'hE0); send(8'h72); send(8'hE0); send(8'h6B);
        send(8'hE0); send(8'hF0); send(8'h72);
        send(8'hE0); send(8'hF0); send(8'h6B); idle(2);

        // Prefix timeout, then ESC
        send(8'hE0); idle(TO + 4); send(8'h76); send(8'hF0); send(8'h76); idle(1);

        // Byte exactly at the timeout cycle wins
        send(8'hE0); idle(TO - 1); send(8'h74); send(8'hE0); send(8'hF0); send(8'h74);

        // Illegal F0 F0, then SPACE
        send(8'hF0); send(8'hF0); send(8'h29); send(8'hF0); send(8'h29); idle(1);

        // E0 E0 restarts, AA/FA ignored, keypad enter
        send(8'hE0); send(8'hE0); send(8'h5A); send(8'hAA); send(8'hFA);
        send(8'hE0); send(8'hF0); send(8'h5A); idle(1);

        // Reset while ENTER held, then press again and a stale break
        send(8'h5A); idle(1);
        step(1'b0, 8'h00, 1'b1);
        send(8'hF0); send(8'h5A); send(8'h5A); send(8'hF0); send(8'h5A); idle(2);

        // Randomized streams
        for (int i = 0; i < int'(N_RND); i++) begin
            int sel;
            int pick;
            sel = int'($urandom_range(0, 99));
            if (sel < 4) begin
                idle(int'($urandom_range(TO - 3, TO + 3)));
            end else if (sel < 5) begin
                step(1'b0, 8'h00, 1'b1);
            end else if (sel < 35) begin
                idle(1);
            end else begin
                logic [7:0] b;
                pick = int'($urandom_range(0, 11));
                b    = (pick == 11) ? 8'($urandom) : pool[pick];
                send(b);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
